// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit memory, issue and redirect bus
// master: fetch unit side; slave: memory arbiter / issue stage / PC update side.
//   fetch_req/fetch_addr/fetch_data/mem_grant : main-memory read port
//   instr_valid/instr_data/instr_pc/instr_ready : issue handshake
//   redirect_valid/redirect_pc : jump-taken restart
//   fetch_count : completed fetch counter
interface instr_fetch_unit_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        mem_grant;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    modport master (
        output fetch_req, fetch_addr, instr_valid, instr_data, instr_pc, fetch_count,
        input  mem_grant, fetch_data, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  fetch_req, fetch_addr, instr_valid, instr_data, instr_pc, fetch_count,
        output mem_grant, fetch_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch with prefetch FIFO and redirect flush
// Ports: clk, rst (async active-high), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_fetch_unit_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fcnt_q, fcnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      word_q [DEPTH];
    logic [31:0]      word_d [DEPTH];
    logic [31:0]      wpc_q  [DEPTH];
    logic [31:0]      wpc_d  [DEPTH];

    logic instr_valid;
    logic fetch_req;
    logic pop;
    logic push;
    logic flush;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fcnt_d   = fcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        word_d   = word_q;
        wpc_d    = wpc_q;

        // A pending redirect hides the head so the issue stage never takes a
        // word from the wrong path.
        instr_valid = (count_q != '0) && !bus.redirect_valid;
        pop         = instr_valid && bus.instr_ready;
        // When full, a same-cycle pop frees the slot the new word lands in.
        fetch_req   = (state_q == S_RUN) && !bus.redirect_valid &&
                      ((count_q < DEPTH_C) || pop);
        push        = fetch_req && bus.mem_grant;
        flush       = bus.redirect_valid && (state_q != S_BOOT);

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_pc;
                end
            end
            default: begin
                state_d = flush ? S_FLUSH : S_RUN;
            end
        endcase

        if (flush) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = bus.fetch_data;
                wpc_d[wr_ptr_q]  = pc_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                pc_d             = pc_q + 32'd1;
                fcnt_d           = fcnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            fcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fcnt_q   <= fcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            word_q   <= word_d;
            wpc_q    <= wpc_d;
        end
    end

    assign bus.fetch_req   = fetch_req;
    assign bus.fetch_addr  = pc_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr_data  = word_q[rd_ptr_q];
    assign bus.instr_pc    = wpc_q[rd_ptr_q];
    assign bus.fetch_count = fcnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA0A0_0000;
    endfunction

    assign bus.fetch_data = memf(bus.fetch_addr);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO contents as a queue of {word, pc}; pc and counter as
    // plain arithmetic; boot/flush as dead-cycle flags.
    logic [63:0]  exp_q[$];
    logic [31:0]  m_pc     = RESET_PC;
    logic [31:0]  m_fc     = 32'd0;
    bit           m_boot   = 1'b1;
    bit           m_flush  = 1'b0;
    bit           sb_popped = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_pc      = RESET_PC;
            m_fc      = 32'd0;
            m_boot    = 1'b1;
            m_flush   = 1'b0;
            sb_popped = 1'b0;
        end else begin
            int  cnt_pre;
            bit  req;
            cnt_pre = exp_q.size() + int'(sb_popped);
            req = !m_boot && !m_flush && !bus.redirect_valid &&
                  ((cnt_pre < DEPTH) || sb_popped);
            if (bus.redirect_valid) begin
                if (!m_boot) exp_q.delete();
                m_pc    = bus.redirect_pc;
                m_flush = !m_boot;
                m_boot  = 1'b0;
            end else begin
                if (req && bus.mem_grant) begin
                    exp_q.push_back({memf(m_pc), m_pc});
                    m_pc = m_pc + 32'd1;
                    m_fc = m_fc + 32'd1;
                end
                m_boot  = 1'b0;
                m_flush = 1'b0;
            end
            sb_popped = 1'b0;
        end
    end

    // Monitor: compares DUT outputs mid-cycle and pops the scoreboard on accept.
    always @(negedge clk) begin
        if (!rst) begin
            bit e_valid, e_pop, e_req;
            logic [63:0] e;
            e_valid = (exp_q.size() != 0) && !bus.redirect_valid;
            e_pop   = e_valid && bus.instr_ready;
            e_req   = !m_boot && !m_flush && !bus.redirect_valid &&
                      ((exp_q.size() < DEPTH) || e_pop);
            chk("fetch_req",   32'(bus.fetch_req),   32'(e_req));
            chk("fetch_addr",  bus.fetch_addr,       m_pc);
            chk("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
            chk("fetch_count", bus.fetch_count,      m_fc);
            if (e_pop) begin
                e = exp_q.pop_front();
                sb_popped = 1'b1;
                chk("instr_data", bus.instr_data, e[63:32]);
                chk("instr_pc",   bus.instr_pc,   e[31:0]);
            end
        end
    end

    task automatic check_reset();
        chk("rst_fetch_req",   32'(bus.fetch_req),   32'd0);
        chk("rst_fetch_addr",  bus.fetch_addr,       RESET_PC);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr_data",  bus.instr_data,       32'd0);
        chk("rst_instr_pc",    bus.instr_pc,         32'd0);
        chk("rst_fetch_count", bus.fetch_count,      32'd0);
    endtask

    task automatic step(input bit g, input bit r, input bit rv, input logic [31:0] rp);
        @(posedge clk);
        #2;
        bus.mem_grant      = g;
        bus.instr_ready    = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, $urandom);
        end
    endtask

    initial begin
        bus.mem_grant      = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        #1;
        check_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        bus.mem_grant   = 1'b1;
        bus.instr_ready = 1'b1;

        repeat (8) step(1, 1, 0, 0);
        repeat (6) step(1, 0, 0, 0);
        repeat (4) step(1, 1, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0040);
        repeat (6) step(1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (10) step(1, 1, 0, 0);
        step(1, 1, 1, 32'hFFFF_FFFE);
        repeat (6) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h0000_0010);
        step(1, 1, 1, 32'h0000_0020);
        repeat (4) step(1, 1, 0, 0);

        rand_steps(3000);

        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.mem_grant      = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        repeat (6) step(1, 1, 0, 0);
        rand_steps(500);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
